// File: rtl/ttt_cpu_player.sv
// rtl/ttt_cpu_player.sv - CPU tic-tac-toe opponent that plays as player 2
module ttt_cpu_player #(
    parameter int THINK_CYCLES = 4,
    parameter int HOLD_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    input  logic [1:0] winner,
    output logic       player2,
    output logic [3:0] player2_pos,
    output logic       busy,
    output logic       move_err
);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_THINK,
        ST_SCAN,
        ST_SELECT,
        ST_ISSUE
    } state_t;

    state_t      state;
    logic [1:0]  live  [9];
    logic [1:0]  board [9];
    logic [15:0] think_cnt;
    logic [15:0] hold_cnt;
    logic [2:0]  line_idx;
    logic        win_valid;
    logic        blk_valid;
    logic [3:0]  win_idx;
    logic [3:0]  blk_idx;

    assign live[0] = pos1;
    assign live[1] = pos2;
    assign live[2] = pos3;
    assign live[3] = pos4;
    assign live[4] = pos5;
    assign live[5] = pos6;
    assign live[6] = pos7;
    assign live[7] = pos8;
    assign live[8] = pos9;

    logic [3:0] n_p1;
    logic [3:0] n_p2;
    logic [3:0] n_empty;
    logic       turn;
    logic       abort;

    always_comb begin
        n_p1    = '0;
        n_p2    = '0;
        n_empty = '0;
        for (int i = 0; i < 9; i++) begin
            if (live[i] == CELL_P1)    n_p1    = n_p1 + 4'd1;
            if (live[i] == CELL_P2)    n_p2    = n_p2 + 4'd1;
            if (live[i] == CELL_EMPTY) n_empty = n_empty + 4'd1;
        end
    end

    assign turn  = enable && (winner == 2'b00) && (n_p1 == n_p2 + 4'd1) && (n_empty != 4'd0);
    assign abort = !enable || (winner != 2'b00);

    // Cell indices of the line examined this SCAN cycle: rows, columns, diagonals
    logic [3:0] la, lb, lc;
    always_comb begin
        case (line_idx)
            3'd0:    {la, lb, lc} = {4'd0, 4'd1, 4'd2};
            3'd1:    {la, lb, lc} = {4'd3, 4'd4, 4'd5};
            3'd2:    {la, lb, lc} = {4'd6, 4'd7, 4'd8};
            3'd3:    {la, lb, lc} = {4'd0, 4'd3, 4'd6};
            3'd4:    {la, lb, lc} = {4'd1, 4'd4, 4'd7};
            3'd5:    {la, lb, lc} = {4'd2, 4'd5, 4'd8};
            3'd6:    {la, lb, lc} = {4'd0, 4'd4, 4'd8};
            default: {la, lb, lc} = {4'd2, 4'd4, 4'd6};
        endcase
    end

    logic [1:0] va, vb, vc;
    logic [1:0] line_p1;
    logic [1:0] line_p2;
    logic       has_gap;
    logic [3:0] gap_idx;
    logic       win_hit;
    logic       blk_hit;

    assign va = board[la];
    assign vb = board[lb];
    assign vc = board[lc];

    always_comb begin
        line_p1 = {1'b0, va == CELL_P1} + {1'b0, vb == CELL_P1} + {1'b0, vc == CELL_P1};
        line_p2 = {1'b0, va == CELL_P2} + {1'b0, vb == CELL_P2} + {1'b0, vc == CELL_P2};
        has_gap = 1'b1;
        gap_idx = lc;
        if (va == CELL_EMPTY)      gap_idx = la;
        else if (vb == CELL_EMPTY) gap_idx = lb;
        else if (vc != CELL_EMPTY) has_gap = 1'b0;
    end

    assign win_hit = (line_p2 == 2'd2) && has_gap;
    assign blk_hit = (line_p1 == 2'd2) && has_gap;

    // Move priority: win, block, centre, corners, edges
    logic [3:0] target;
    logic       target_ok;
    always_comb begin
        target    = '0;
        target_ok = 1'b1;
        if (win_valid)                     target = win_idx;
        else if (blk_valid)                target = blk_idx;
        else if (board[4] == CELL_EMPTY)   target = 4'd4;
        else if (board[0] == CELL_EMPTY)   target = 4'd0;
        else if (board[2] == CELL_EMPTY)   target = 4'd2;
        else if (board[6] == CELL_EMPTY)   target = 4'd6;
        else if (board[8] == CELL_EMPTY)   target = 4'd8;
        else if (board[1] == CELL_EMPTY)   target = 4'd1;
        else if (board[3] == CELL_EMPTY)   target = 4'd3;
        else if (board[5] == CELL_EMPTY)   target = 4'd5;
        else if (board[7] == CELL_EMPTY)   target = 4'd7;
        else                               target_ok = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            player2     <= 1'b0;
            player2_pos <= '0;
            move_err    <= 1'b0;
            think_cnt   <= '0;
            hold_cnt    <= '0;
            line_idx    <= '0;
            win_valid   <= 1'b0;
            blk_valid   <= 1'b0;
            win_idx     <= '0;
            blk_idx     <= '0;
            for (int i = 0; i < 9; i++) board[i] <= CELL_EMPTY;
        end else begin
            move_err <= 1'b0;
            if (state != ST_IDLE && abort) begin
                state   <= ST_IDLE;
                player2 <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (turn) begin
                            for (int i = 0; i < 9; i++) board[i] <= live[i];
                            think_cnt <= 16'(THINK_CYCLES - 1);
                            line_idx  <= '0;
                            win_valid <= 1'b0;
                            blk_valid <= 1'b0;
                            win_idx   <= '0;
                            blk_idx   <= '0;
                            state     <= ST_THINK;
                        end
                    end
                    ST_THINK: begin
                        if (think_cnt == 16'd0) state <= ST_SCAN;
                        else                    think_cnt <= think_cnt - 16'd1;
                    end
                    ST_SCAN: begin
                        if (win_hit && !win_valid) begin
                            win_valid <= 1'b1;
                            win_idx   <= gap_idx;
                        end
                        if (blk_hit && !blk_valid) begin
                            blk_valid <= 1'b1;
                            blk_idx   <= gap_idx;
                        end
                        if (line_idx == 3'd7) state <= ST_SELECT;
                        line_idx <= line_idx + 3'd1;
                    end
                    ST_SELECT: begin
                        if (target_ok) begin
                            player2     <= 1'b1;
                            player2_pos <= target;
                            hold_cnt    <= 16'(HOLD_TIMEOUT - 1);
                            state       <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_ISSUE: begin
                        // The game core confirms by writing 10; a 01 means player 1 got there first
                        if (live[player2_pos] == CELL_P2 || live[player2_pos] == CELL_P1) begin
                            player2 <= 1'b0;
                            state   <= ST_IDLE;
                        end else if (hold_cnt == 16'd0) begin
                            player2  <= 1'b0;
                            move_err <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt - 16'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ttt_cpu_player.sv
// tb/tb_ttt_cpu_player.sv - self-checking bench for ttt_cpu_player
module tb_ttt_cpu_player;

    localparam int THINK = 4;
    localparam int HOLD  = 16;
    localparam int LAT   = THINK + 9;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] winner = 2'b00;
    logic [1:0] cells [9];
    logic       player2;
    logic [3:0] player2_pos;
    logic       busy;
    logic       move_err;

    ttt_cpu_player #(.THINK_CYCLES(THINK), .HOLD_TIMEOUT(HOLD)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pos1        (cells[0]),
        .pos2        (cells[1]),
        .pos3        (cells[2]),
        .pos4        (cells[3]),
        .pos5        (cells[4]),
        .pos6        (cells[5]),
        .pos7        (cells[6]),
        .pos8        (cells[7]),
        .pos9        (cells[8]),
        .winner      (winner),
        .player2     (player2),
        .player2_pos (player2_pos),
        .busy        (busy),
        .move_err    (move_err)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [8:0] p1;
        logic [8:0] p2;
        int         exp_pos;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_board(input logic [8:0] p1, input logic [8:0] p2);
        for (int i = 0; i < 9; i++)
            cells[i] = p1[i] ? 2'b01 : (p2[i] ? 2'b10 : 2'b00);
    endtask

    task automatic idle_out();
        enable = 1'b0;
        winner = 2'b00;
        tick();
        tick();
    endtask

    // Raise enable on a ready board; lat = edges after the trigger edge until player2 seen
    task automatic trigger_and_wait(output int lat);
        enable = 1'b1;
        tick();
        check("busy_after_trigger", int'(busy), 1);
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            tick();
            if (player2) lat = k;
        end
    endtask

    // Reference move chooser straight from the game rules
    function automatic int ref_move();
        int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        int pref [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};
        int win = -1;
        int blk = -1;
        for (int l = 0; l < 8; l++) begin
            int n1 = 0;
            int n2 = 0;
            int gap = -1;
            for (int c = 0; c < 3; c++) begin
                if (cells[ln[l][c]] == 2'b01) n1++;
                else if (cells[ln[l][c]] == 2'b10) n2++;
                else if (cells[ln[l][c]] == 2'b00) gap = ln[l][c];
            end
            if (n2 == 2 && gap >= 0 && win < 0) win = gap;
            if (n1 == 2 && gap >= 0 && blk < 0) blk = gap;
        end
        if (win >= 0) return win;
        if (blk >= 0) return blk;
        for (int i = 0; i < 9; i++)
            if (cells[pref[i]] == 2'b00) return pref[i];
        return -1;
    endfunction

    initial begin
        int lat;
        int tgt;
        int hi_cnt;
        int err_at_drop;
        int perm [9];
        int j;
        int tmp;
        int k;
        int seen;

        vecs[0] = '{9'h010, 9'h000, 0};
        vecs[1] = '{9'h003, 9'h010, 2};
        vecs[2] = '{9'h103, 9'h018, 5};
        vecs[3] = '{9'h001, 9'h000, 4};
        vecs[4] = '{9'h011, 9'h100, 2};
        vecs[5] = '{9'h111, 9'h044, 1};
        vecs[6] = '{9'h109, 9'h090, 1};
        vecs[7] = '{9'h023, 9'h014, 6};

        for (int i = 0; i < 9; i++) cells[i] = 2'b00;
        reset = 1'b1;
        tick();
        tick();
        check("reset_player2", int'(player2), 0);
        check("reset_pos", int'(player2_pos), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_move_err", int'(move_err), 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            set_board(vecs[v].p1, vecs[v].p2);
            trigger_and_wait(lat);
            check("vec_latency", lat, LAT);
            check("vec_pos", int'(player2_pos), vecs[v].exp_pos);
            if (lat > 0) begin
                tgt = vecs[v].exp_pos;
                cells[tgt] = 2'b10;
                tick();
                check("vec_confirm_p2", int'(player2), 0);
                check("vec_confirm_busy", int'(busy), 0);
                check("vec_pos_retained", int'(player2_pos), tgt);
                tick();
                tick();
                tick();
                check("vec_no_retrigger", int'(busy), 0);
            end
            idle_out();
        end

        // Hold timeout with an unchanged board
        set_board(9'h010, 9'h000);
        trigger_and_wait(lat);
        check("to_latency", lat, LAT);
        hi_cnt = (lat > 0) ? 1 : 0;
        err_at_drop = 0;
        seen = 0;
        for (int c = 0; c < 40 && lat > 0 && seen == 0; c++) begin
            tick();
            if (player2) hi_cnt++;
            else begin
                seen = 1;
                err_at_drop = int'(move_err);
            end
        end
        enable = 1'b0;
        check("to_high_cycles", hi_cnt, HOLD);
        check("to_move_err_pulse", err_at_drop, 1);
        tick();
        check("to_move_err_single", int'(move_err), 0);
        check("to_idle", int'(busy), 0);
        idle_out();

        // Winner forced during THINK
        set_board(9'h010, 9'h000);
        enable = 1'b1;
        tick();
        tick();
        winner = 2'b01;
        tick();
        check("win_abort_busy", int'(busy), 0);
        hi_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (player2) hi_cnt++;
        end
        check("win_abort_no_move", hi_cnt, 0);
        idle_out();

        // Enable dropped during SCAN
        set_board(9'h010, 9'h000);
        enable = 1'b1;
        for (int c = 0; c < THINK + 3; c++) tick();
        check("scan_busy", int'(busy), 1);
        enable = 1'b0;
        tick();
        check("scan_abort_busy", int'(busy), 0);
        check("scan_abort_p2", int'(player2), 0);
        idle_out();

        // Player 1 takes the target cell while the move is held
        set_board(9'h003, 9'h010);
        trigger_and_wait(lat);
        check("p1_take_latency", lat, LAT);
        cells[2] = 2'b01;
        tick();
        check("p1_take_p2", int'(player2), 0);
        check("p1_take_err", int'(move_err), 0);
        tick();
        tick();
        check("p1_take_idle", int'(busy), 0);
        idle_out();

        // Reset while the move is held
        set_board(9'h010, 9'h000);
        trigger_and_wait(lat);
        check("rst_issue_latency", lat, LAT);
        reset = 1'b1;
        tick();
        check("rst_issue_p2", int'(player2), 0);
        check("rst_issue_err", int'(move_err), 0);
        check("rst_issue_busy", int'(busy), 0);
        check("rst_issue_pos", int'(player2_pos), 0);
        enable = 1'b0;
        reset = 1'b0;
        tick();

        // Equal counts is not player 2's turn
        set_board(9'h001, 9'h010);
        enable = 1'b1;
        tick();
        tick();
        tick();
        check("no_turn_busy", int'(busy), 0);
        idle_out();

        // Random legal boards against the reference chooser
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 9; i++) perm[i] = i;
            for (int i = 8; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                tmp = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            k = int'($urandom_range(3, 0));
            for (int i = 0; i < 9; i++) cells[i] = 2'b00;
            for (int i = 0; i <= k; i++) cells[perm[i]] = 2'b01;
            for (int i = k + 1; i <= 2 * k; i++) cells[perm[i]] = 2'b10;
            tgt = ref_move();
            trigger_and_wait(lat);
            check("rnd_latency", lat, LAT);
            check("rnd_pos", int'(player2_pos), tgt);
            if (lat > 0 && tgt >= 0) begin
                cells[tgt] = 2'b10;
                tick();
                check("rnd_confirm", int'(player2), 0);
            end
            idle_out();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ttt_cpu_player.md
TTT_CPU_PLAYER -- requirements
Module: ttt_cpu_player

Interface
REQ-001 Parameter THINK_CYCLES, default 4: idle delay, in cycles, before the board scan starts (minimum 1).
REQ-002 Parameter HOLD_TIMEOUT, default 16: maximum cycles player2 is held without the move being confirmed.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. Ports are named clock and reset.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 enable  input  1  1 = the CPU plays as player 2.
REQ-007 pos1..pos9  input  2 each  board cells, indices 0..8; 00 empty, 01 player 1, 10 player 2.
REQ-008 winner  input  2  00 none, 01 player 1, 10 player 2, 11 draw.
REQ-009 player2  output  1  move strobe to the game core, held until the move is confirmed.
REQ-010 player2_pos  output  4  cell index 0..8 of the move, stable while player2 = 1.
REQ-011 busy  output  1  1 in any state other than IDLE.
REQ-012 move_err  output  1  one-cycle pulse on a hold timeout.

Function
REQ-013 The FSM SHALL have the states IDLE, THINK, SCAN, SELECT and ISSUE.
REQ-014 Turn condition: enable = 1, winner = 00, count(01) = count(10) + 1, and at least one cell is 00.
REQ-015 IDLE -> THINK on an edge that samples the turn condition true; that same edge snapshots pos1..pos9 into an internal board register.
REQ-016 THINK SHALL last exactly THINK_CYCLES cycles, counted by a down-counter, then go to SCAN.
REQ-017 SCAN SHALL evaluate one line of the snapshot per cycle for 8 cycles, in this order: rows (0,1,2), (3,4,5), (6,7,8); columns (0,3,6), (1,4,7), (2,5,8); diagonals (0,4,8), (2,4,6).
REQ-018 In each SCAN cycle: a line with two 10 cells and one 00 cell records a win candidate; a line with two 01 cells and one 00 cell records a block candidate.
REQ-019 For each candidate type, only the first line found (scan order) is kept; the recorded index is that line's empty cell.
REQ-020 SELECT (1 cycle) SHALL pick the target in this priority:
- win candidate;
- block candidate;
- cell 4 if empty;
- the first empty corner in order 0, 2, 6, 8;
- the first empty edge in order 1, 3, 5, 7.
REQ-021 The SELECT -> ISSUE edge SHALL register player2 = 1 and player2_pos = target; player2 is therefore first high THINK_CYCLES + 9 edges after the edge that sampled the turn condition.
REQ-022 In ISSUE, player2 and player2_pos SHALL hold constant.
REQ-023 Exit from ISSUE:
- live target cell reads 10 (confirm): the next edge deasserts player2 and returns to IDLE;
- live target cell reads 01: abort to IDLE with player2 = 0 and no error;
- HOLD_TIMEOUT cycles elapse with neither: deassert player2, pulse move_err for 1 cycle, return to IDLE.
REQ-024 In THINK, SCAN, SELECT or ISSUE, enable = 0 or winner != 00 SHALL return the FSM to IDLE on the next edge with player2 = 0 and no move issued; this abort takes priority over the other transitions.
REQ-025 After a confirmed move, cell counts are equal, so no re-trigger occurs until player 1 moves again.
REQ-026 player2_pos SHALL retain its last value when player2 = 0.
REQ-027 The full-board case is impossible once in SCAN because of REQ-014; if the snapshot has no empty cell, SELECT SHALL return to IDLE without issuing.

Reset
REQ-028 While reset = 1 at an edge: state = IDLE, player2 = 0, player2_pos = 4'b0000, busy = 0, move_err = 0, all counters and candidate registers cleared.
REQ-029 Reset asserted in any state, including ISSUE, SHALL abort on that edge with no move_err pulse.

Verification
REQ-030 P1 at {4}, P2 none, enable = 1, THINK_CYCLES = 4 -> player2 rises 13 edges after the trigger edge with player2_pos = 0.
REQ-031 P1 at {0,1}, P2 at {4} -> player2_pos = 2 (block).
REQ-032 P1 at {0,1,8}, P2 at {3,4} -> player2_pos = 5: the win on row 1 beats the block at 2.
REQ-033 Valid move issued, board held unchanged -> player2 high for exactly HOLD_TIMEOUT = 16 cycles, then drops; move_err high for 1 cycle.
REQ-034 Turn triggered, winner = 01 forced during THINK -> player2 never asserts, busy = 0 on the following edge.
REQ-035 Move issued, bench writes 10 into the target cell -> player2 = 0 on the next edge; busy = 0, and no re-trigger occurs.
